// File: rtl/uart_pkg.sv
// Shared UART state encodings for the receiver and transmitter, plus small timing helpers.
package uart_pkg;

  // Receiver state encodings
  localparam logic [1:0] RX_IDLE_ENC  = 2'd0;
  localparam logic [1:0] RX_START_ENC = 2'd1;
  localparam logic [1:0] RX_DATA_ENC  = 2'd2;
  localparam logic [1:0] RX_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    RX_IDLE  = RX_IDLE_ENC,
    RX_START = RX_START_ENC,
    RX_DATA  = RX_DATA_ENC,
    RX_STOP  = RX_STOP_ENC
  } rx_state_t;

  // Transmitter state encodings
  localparam logic [1:0] TX_IDLE_ENC  = 2'd0;
  localparam logic [1:0] TX_START_ENC = 2'd1;
  localparam logic [1:0] TX_DATA_ENC  = 2'd2;
  localparam logic [1:0] TX_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = TX_IDLE_ENC,
    TX_START = TX_START_ENC,
    TX_DATA  = TX_DATA_ENC,
    TX_STOP  = TX_STOP_ENC
  } tx_state_t;

  // Timer value at which the middle of the start bit is checked
  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

  // Timer value at which a full bit period has elapsed
  function automatic int full_bit_last(input int clks_per_bit);
    return clks_per_bit - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector
// on the synchronized value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronizer chain and one-cycle history; reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_s = sync;
  // Only a 1 -> 0 transition counts, so a line held low never retriggers
  assign fall = prev & ~sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/stop framing with a single-entry holding
// register, framing-error and overrun-error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int INDEX_W = $clog2(DATA_BITS);

  localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(half_bit_last(CLKS_PER_BIT));
  localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(full_bit_last(CLKS_PER_BIT));
  localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic [TIMER_W-1:0]   timer;
  logic [INDEX_W-1:0]   index;
  logic [DATA_BITS-1:0] shreg;

  logic rx_s;
  logic fall;

  logic timer_clr;
  logic index_clr;
  logic sample_bit;
  logic stop_good;
  logic stop_bad;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle strobes for the datapath
  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    index_clr  = 1'b0;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      RX_IDLE: begin
        // Timer is parked at zero while idle so it never free-runs
        timer_clr = 1'b1;
        if (fall) begin
          state_next = RX_START;
        end
      end
      RX_START: begin
        if (timer == HALF_LAST) begin
          timer_clr = 1'b1;
          if (!rx_s) begin
            state_next = RX_DATA;
            index_clr  = 1'b1;
          end else begin
            // Line went back high before mid-start: treat as a glitch
            state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (timer == BIT_LAST) begin
          timer_clr  = 1'b1;
          sample_bit = 1'b1;
          if (index == INDEX_LAST) begin
            state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (timer == BIT_LAST) begin
          timer_clr  = 1'b1;
          state_next = RX_IDLE;
          if (rx_s) begin
            stop_good = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

  // Bit timer, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      index <= '0;
      shreg <= '0;
    end else begin
      if (timer_clr) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (index_clr) begin
        index <= '0;
      end else if (sample_bit && (index != INDEX_LAST)) begin
        index <= index + 1'b1;
      end
      if (sample_bit) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
    end
  end

  // Holding register, ready flag and error pulses; a load wins over a same-cycle rd_ack
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_good & rx_ready & ~rd_ack;
      if (stop_good) begin
        rx_data  <= shreg;
        rx_ready <= 1'b1;
      end else if (rd_ack) begin
        rx_ready <= 1'b0;
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule
